// File: rtl/window_pkg.sv
// window_pkg: shared constants and types for sample_window8.
//   WIN_DEPTH     - samples per window
//   SHIFT_DEFAULT - shift amount the averager uses (three shifts of 1 = /8)
//   state_t       - window FSM state: collecting samples / sliding window full
package window_pkg;

    localparam int WIN_DEPTH     = 8;
    localparam int SHIFT_DEFAULT = 1;

    typedef enum logic {
        ST_FILL = 1'b0,
        ST_FULL = 1'b1
    } state_t;

endpackage

// File: rtl/win_shift8.sv
// win_shift8: 8-entry shift register with parallel outputs.
//   clk, rst    - rising-edge clock, asynchronous active-low reset
//   clr         - synchronous clear of all entries (highest priority)
//   load_en     - parallel load of all entries from load_data
//   shift_en    - shift toward entry 0; din enters at entry WIN_DEPTH-1
//   q           - entry 0 is the oldest sample, entry WIN_DEPTH-1 the newest
module win_shift8
    import window_pkg::*;
#(
    parameter int DATAWIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clr,
    input  logic                 load_en,
    input  logic                 shift_en,
    input  logic [DATAWIDTH-1:0] din,
    input  logic [DATAWIDTH-1:0] load_data [WIN_DEPTH],
    output logic [DATAWIDTH-1:0] q         [WIN_DEPTH]
);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < WIN_DEPTH; i++) q[i] <= '0;
        end else if (clr) begin
            for (int i = 0; i < WIN_DEPTH; i++) q[i] <= '0;
        end else if (load_en) begin
            for (int i = 0; i < WIN_DEPTH; i++) q[i] <= load_data[i];
        end else if (shift_en) begin
            for (int i = 0; i < WIN_DEPTH - 1; i++) q[i] <= q[i+1];
            q[WIN_DEPTH-1] <= din;
        end
    end

endmodule

// File: rtl/sample_window8.sv
// sample_window8: assembles a serial stream of signed samples into an
// 8-sample window for the averager.
//   Clk, rst       - rising-edge clock, asynchronous active-low reset
//   in_data/in_valid/in_ready - sample input handshake
//   hold           - downstream stall, freezes all state
//   flush          - synchronous clear of the window (wins over hold)
//   mode           - 0 sliding, 1 block; sampled only while count == 0 in FILL
//   a..h           - window taps, a oldest, h newest
//   sa             - constant shift amount for the averager
//   win_valid      - one-cycle strobe: a new window is on the taps
//   count          - samples held in the current fill (0..8)
//   state_dbg      - current FSM state
//
// Handshake: a sample is consumed on a rising edge exactly when
// in_valid && in_ready; in_ready = !flush && !hold and does not depend on
// in_valid. The producer must hold in_data stable while in_valid is high
// and not yet accepted.
module sample_window8
    import window_pkg::*;
#(
    parameter int DATAWIDTH = 16,
    parameter int SAWIDTH   = 8,
    parameter int SHIFT     = SHIFT_DEFAULT
) (
    input  logic                 Clk,
    input  logic                 rst,
    input  logic [DATAWIDTH-1:0] in_data,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic                 hold,
    input  logic                 flush,
    input  logic                 mode,
    output logic [DATAWIDTH-1:0] a,
    output logic [DATAWIDTH-1:0] b,
    output logic [DATAWIDTH-1:0] c,
    output logic [DATAWIDTH-1:0] d,
    output logic [DATAWIDTH-1:0] e,
    output logic [DATAWIDTH-1:0] f,
    output logic [DATAWIDTH-1:0] g,
    output logic [DATAWIDTH-1:0] h,
    output logic [SAWIDTH-1:0]   sa,
    output logic                 win_valid,
    output logic [3:0]           count,
    output state_t               state_dbg
);

    state_t     state_q, state_d;
    logic [3:0] count_d;
    logic       mode_q, mode_d, mode_eff;
    logic       win_valid_d;
    logic       accept;
    logic       clr;
    logic       tap_shift, tap_load, stg_shift;

    logic [DATAWIDTH-1:0] tap_q    [WIN_DEPTH];
    logic [DATAWIDTH-1:0] stage_q  [WIN_DEPTH];
    logic [DATAWIDTH-1:0] load_win [WIN_DEPTH];
    logic [DATAWIDTH-1:0] zero_win [WIN_DEPTH];
    logic [DATAWIDTH-1:0] stage_unused;

    assign in_ready = !flush && !hold;
    assign accept   = in_valid && in_ready;

    // The mode latch is transparent on the edge that starts a fill, so the
    // first sample of a fill already obeys the newly sampled mode.
    assign mode_eff = (count == 4'd0 && state_q == ST_FILL) ? mode : mode_q;

    // Block completion: staging holds samples 1..7 in entries 1..7 after seven
    // shifts; the eighth sample goes straight to h. Entry 0 is stale there.
    always_comb begin
        for (int i = 0; i < WIN_DEPTH - 1; i++) load_win[i] = stage_q[i+1];
        load_win[WIN_DEPTH-1] = in_data;
        for (int i = 0; i < WIN_DEPTH; i++) zero_win[i] = '0;
    end
    assign stage_unused = stage_q[0];

    always_comb begin
        state_d     = state_q;
        count_d     = count;
        mode_d      = mode_q;
        win_valid_d = 1'b0;
        clr         = 1'b0;
        tap_shift   = 1'b0;
        tap_load    = 1'b0;
        stg_shift   = 1'b0;

        if (flush) begin
            clr     = 1'b1;
            count_d = 4'd0;
            state_d = ST_FILL;
            mode_d  = mode;
        end else if (!hold) begin
            if (count == 4'd0 && state_q == ST_FILL) mode_d = mode;
            if (accept) begin
                if (!mode_eff) begin
                    tap_shift = 1'b1;
                    if (state_q == ST_FULL) begin
                        win_valid_d = 1'b1;
                    end else if (count == 4'd7) begin
                        state_d     = ST_FULL;
                        count_d     = 4'd8;
                        win_valid_d = 1'b1;
                    end else begin
                        count_d = count + 4'd1;
                    end
                end else begin
                    stg_shift = 1'b1;
                    if (count == 4'd7) begin
                        tap_load    = 1'b1;
                        count_d     = 4'd0;
                        win_valid_d = 1'b1;
                    end else begin
                        count_d = count + 4'd1;
                    end
                end
            end
        end
    end

    always_ff @(posedge Clk or negedge rst) begin
        if (!rst) begin
            state_q   <= ST_FILL;
            count     <= 4'd0;
            mode_q    <= 1'b0;
            win_valid <= 1'b0;
            sa        <= SAWIDTH'(SHIFT);
        end else begin
            state_q   <= state_d;
            count     <= count_d;
            mode_q    <= mode_d;
            win_valid <= win_valid_d;
            sa        <= SAWIDTH'(SHIFT);
        end
    end

    win_shift8 #(.DATAWIDTH(DATAWIDTH)) u_taps (
        .clk       (Clk),
        .rst       (rst),
        .clr       (clr),
        .load_en   (tap_load),
        .shift_en  (tap_shift),
        .din       (in_data),
        .load_data (load_win),
        .q         (tap_q)
    );

    win_shift8 #(.DATAWIDTH(DATAWIDTH)) u_stage (
        .clk       (Clk),
        .rst       (rst),
        .clr       (clr),
        .load_en   (1'b0),
        .shift_en  (stg_shift),
        .din       (in_data),
        .load_data (zero_win),
        .q         (stage_q)
    );

    assign a = tap_q[0];
    assign b = tap_q[1];
    assign c = tap_q[2];
    assign d = tap_q[3];
    assign e = tap_q[4];
    assign f = tap_q[5];
    assign g = tap_q[6];
    assign h = tap_q[7];

    assign state_dbg = state_q;

endmodule

// File: tb/tb_sample_window8.sv
module tb_sample_window8;
  import window_pkg::*;

  logic        clk;
  logic        rst;
  logic [15:0] in_data;
  logic        in_valid;
  logic        in_ready;
  logic        hold;
  logic        flush;
  logic        mode;
  logic [15:0] a, b, c, d, e, f, g, h;
  logic [7:0]  sa;
  logic        win_valid;
  logic [3:0]  count;
  state_t      state_dbg;

  logic [127:0] taps;
  logic [127:0] exp_q[$];
  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic [15:0]  data;
    logic         valid;
    logic         flush;
    logic         hold;
    logic         mode;
    logic         exp_rdy;
    logic [3:0]   exp_count;
    logic         exp_wv;
    logic [127:0] exp_taps;
  } vec_t;

  vec_t vecs[$];

  sample_window8 dut (
    .Clk       (clk),
    .rst       (rst),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .hold      (hold),
    .flush     (flush),
    .mode      (mode),
    .a         (a),
    .b         (b),
    .c         (c),
    .d         (d),
    .e         (e),
    .f         (f),
    .g         (g),
    .h         (h),
    .sa        (sa),
    .win_valid (win_valid),
    .count     (count),
    .state_dbg (state_dbg)
  );

  assign taps = {a, b, c, d, e, f, g, h};

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // helpers
  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // window after i sliding accepts of samples 1,2,3,...
  function automatic logic [127:0] slide_win(input int i);
    logic [127:0] w;
    int v;
    w = '0;
    for (int k = 0; k < 8; k++) begin
      v = i - 7 + k;
      w[127-16*k -: 16] = (v < 1) ? 16'd0 : 16'(v);
    end
    return w;
  endfunction

  // block window of consecutive samples starting at base
  function automatic logic [127:0] blk_win(input int base);
    logic [127:0] w;
    for (int k = 0; k < 8; k++) w[127-16*k -: 16] = 16'(base + k);
    return w;
  endfunction

  task automatic add(input logic [15:0] dd, input logic v, input logic fl, input logic ho,
                     input logic m, input logic rdy, input logic [3:0] cnt, input logic wv,
                     input logic [127:0] tp);
    vec_t r;
    r.data = dd; r.valid = v; r.flush = fl; r.hold = ho; r.mode = m;
    r.exp_rdy = rdy; r.exp_count = cnt; r.exp_wv = wv; r.exp_taps = tp;
    vecs.push_back(r);
  endtask

  // driver: present inputs, take one rising edge, land 1 time unit after it
  task automatic step(input logic [15:0] dd, input logic v, input logic fl, input logic ho,
                      input logic m);
    in_data = dd; in_valid = v; flush = fl; hold = ho; mode = m;
    @(posedge clk);
    #1;
  endtask

  // scoreboard: every win_valid cycle must match the oldest expected window
  always @(negedge clk) begin
    if (rst === 1'b1 && win_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_window: got %h expected none", taps);
      end else begin
        chk("window", taps, exp_q.pop_front());
      end
    end
  end

  initial begin
    rst = 1'b0; in_data = '0; in_valid = 0; flush = 0; hold = 0; mode = 0;

    // ---- reset state ----
    repeat (2) @(posedge clk);
    #1;
    chk("rst_taps", taps, '0);
    chk("rst_count", count, 0);
    chk("rst_win_valid", win_valid, 0);
    chk("rst_sa", sa, 8'd1);
    chk("rst_state", state_dbg, ST_FILL);
    @(negedge clk) rst = 1'b1;

    // ---- asynchronous reset mid-fill ----
    for (int i = 1; i <= 5; i++) step(16'(i), 1, 0, 0, 0);
    chk("midfill_count", count, 5);
    chk("midfill_h", h, 16'd5);
    rst = 1'b0;
    #1;
    chk("async_rst_count", count, 0);
    chk("async_rst_taps", taps, '0);
    @(negedge clk) rst = 1'b1;

    // ---- vector table ----
    // sliding 1..10
    for (int i = 1; i <= 10; i++)
      add(16'(i), 1, 0, 0, 0, 1, (i < 8) ? 4'(i) : 4'd8, i >= 8, slide_win(i));
    // hold in sliding FULL: nothing accepted, everything frozen
    for (int i = 0; i < 3; i++)
      add(16'd99, 1, 0, 1, 0, 0, 4'd8, 0, slide_win(10));
    add(16'd11, 1, 0, 0, 0, 1, 4'd8, 1, slide_win(11));
    // flush with a coincident sample, selecting block mode
    add(16'h7FFF, 1, 1, 0, 1, 0, 4'd0, 0, '0);
    // block 1..16
    for (int i = 1; i <= 16; i++)
      add(16'(i), 1, 0, 0, 1, 1, 4'(i % 8), (i % 8) == 0,
          (i < 8) ? 128'd0 : (i < 16) ? blk_win(1) : blk_win(9));
    // partial fill to count 4, then flush with a coincident sample
    for (int i = 17; i <= 20; i++)
      add(16'(i), 1, 0, 0, 1, 1, 4'(i - 16), 0, blk_win(9));
    add(16'h7FFF, 1, 1, 0, 1, 0, 4'd0, 0, '0);
    // clean window after the flush
    for (int i = 21; i <= 28; i++)
      add(16'(i), 1, 0, 0, 1, 1, 4'((i - 20) % 8), i == 28, (i < 28) ? 128'd0 : blk_win(21));

    foreach (vecs[n]) begin
      in_data = vecs[n].data; in_valid = vecs[n].valid; flush = vecs[n].flush;
      hold = vecs[n].hold; mode = vecs[n].mode;
      #1;
      chk($sformatf("v%0d_in_ready", n), in_ready, vecs[n].exp_rdy);
      if (vecs[n].exp_wv) exp_q.push_back(vecs[n].exp_taps);
      @(posedge clk);
      #1;
      chk($sformatf("v%0d_count", n), count, vecs[n].exp_count);
      chk($sformatf("v%0d_win_valid", n), win_valid, vecs[n].exp_wv);
      chk($sformatf("v%0d_taps", n), taps, vecs[n].exp_taps);
    end

    // ---- mode change mid-fill is ignored; negative samples bit-exact ----
    step(16'd0, 0, 1, 0, 0);
    chk("seq_flush_count", count, 0);
    step(16'd100, 1, 0, 0, 0);
    step(16'd101, 1, 0, 0, 0);
    step(16'd102, 1, 0, 0, 0);
    step(16'h8000, 1, 0, 0, 1);
    step(16'hFFFF, 1, 0, 0, 1);
    step(16'd103, 1, 0, 0, 1);
    step(16'd104, 1, 0, 0, 1);
    exp_q.push_back({16'd100, 16'd101, 16'd102, 16'h8000, 16'hFFFF, 16'd103, 16'd104, 16'd105});
    step(16'd105, 1, 0, 0, 1);
    chk("toggle_count8", count, 8);
    chk("toggle_state", state_dbg, ST_FULL);
    chk("toggle_win_valid", win_valid, 1);
    exp_q.push_back({16'd101, 16'd102, 16'h8000, 16'hFFFF, 16'd103, 16'd104, 16'd105, 16'd106});
    step(16'd106, 1, 0, 0, 1);
    chk("toggle_slide_h", h, 16'd106);
    chk("toggle_slide_a", a, 16'd101);

    // flush reloads the mode: block behaviour from here on
    step(16'd0, 0, 1, 0, 1);
    chk("flush2_state", state_dbg, ST_FILL);
    step(16'hFFFF, 1, 0, 0, 1);
    chk("blk_neg_count1", count, 1);
    chk("blk_neg_taps_clear", taps, '0);
    step(16'h8000, 1, 0, 0, 1);
    for (int i = 1; i <= 5; i++) step(16'(i), 1, 0, 0, 1);
    exp_q.push_back({16'hFFFF, 16'h8000, 16'd1, 16'd2, 16'd3, 16'd4, 16'd5, 16'h7FFF});
    step(16'h7FFF, 1, 0, 0, 1);
    chk("blk_neg_count0", count, 0);
    chk("blk_neg_win_valid", win_valid, 1);
    chk("blk_neg_state", state_dbg, ST_FILL);

    // idle: strobe self-clears, nothing left outstanding
    step(16'd0, 0, 0, 0, 1);
    chk("idle_win_valid", win_valid, 0);
    repeat (3) step(16'd0, 0, 0, 0, 1);
    chk("queue_empty", 128'(exp_q.size()), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
